led_mode_sequencer: RTL
=======================

// Module: led_mode_sequencer
// PURPOSE
//  Front-panel controller for the 4-rate LED blink selector. Debounces one raw
//  push-button and steps an FSM through OFF/100Hz/50Hz/10Hz/1Hz. The FSM drives
//  the selector's enable and two switch inputs. Optional auto-cycle mode rotates
//  through the four rates on a dwell timer. Sits between board I/O and the blink selector.
// PARAMETERS
//  c_DEBOUNCE_CNT  250     consecutive stable clocks to accept a button level (10 ms @ 25 kHz)
//  c_DWELL_CNT     125000  clocks per rate in auto-cycle mode (5 s @ 25 kHz)
// PORTS
//  i_clock        in   1  system clock (25 kHz nominal)
//  i_reset        in   1  synchronous, active-high reset
//  i_button       in   1  raw push-button, asynchronous, active-high, may bounce
//  i_auto_en      in   1  1 = auto-cycle rates on dwell timer (synchronous level)
//  o_enable       out  1  to selector i_enable; 0 only in S_OFF
//  o_switch_1     out  1  to selector i_switch_1
//  o_switch_2     out  1  to selector i_switch_2
//  o_mode         out  3  current state encoding (S_OFF=0, S_MODE0..3=1..4)
//  o_mode_change  out  1  one-clock pulse, cycle after any state change
// BEHAVIOUR
//  Reset (all values, same edge): state=S_OFF; o_enable=0; o_switch_2/1=00;
//   o_mode=0; o_mode_change=0. Sync FFs, debounced level, debounce and dwell counters = 0.
//  Synchronizer: 2-FF chain on i_button; only the 2nd stage is used downstream.
//  Debounce: counter increments while sync != debounced level. Counter clears
//   whenever they are equal. When counter == c_DEBOUNCE_CNT-1 and they still
//   differ, debounced level <= sync and counter <= 0. Pulses shorter than
//   c_DEBOUNCE_CNT clocks never change the debounced level.
//  Press = debounced rising edge (1 clock). Release has no effect.
//  Latency: raw rise first sampled at edge 1 -> state/outputs update at edge
//   c_DEBOUNCE_CNT+3 (exact).
//  FSM, on press: S_OFF->S_MODE0->S_MODE1->S_MODE2->S_MODE3->S_OFF.
//  Outputs are decoded from the state register (no extra latency):
//   S_OFF: en=0, sw2/sw1=00. S_MODE0: en=1, 00 (100 Hz). S_MODE1: en=1, 01 (50 Hz).
//   S_MODE2: en=1, 10 (10 Hz). S_MODE3: en=1, 11 (1 Hz).
//  Dwell counter (32 bit):
//   - Counts only in S_MODE0..3 while i_auto_en=1.
//   - Held at 0 in S_OFF or when i_auto_en=0.
//   - Cleared on every state change.
//   - At c_DWELL_CNT-1: advance S_MODE0->1->2->3->S_MODE0 (wraps, never enters
//     S_OFF) and counter <= 0.
//  Simultaneous press and dwell expiry: press transition wins, dwell counter cleared.
//   The state advances exactly one step.
//  o_mode_change: registered; =1 for exactly one clock, the cycle after the state register changes.
//  Reset mid-debounce or mid-dwell: all progress discarded. A button held across
//   reset release is a new press after c_DEBOUNCE_CNT+3 clocks.
//  i_auto_en toggled mid-dwell: counter clears; the next dwell interval starts from 0.
// TESTING (override c_DEBOUNCE_CNT=4, c_DWELL_CNT=20)
//  1 Reset, hold i_button=1 (clean) -> o_mode 0->1 at edge 7 (D+3), o_enable=1,
//    sw=00, o_mode_change=1 for one clock.
//  2 Bounce i_button 1/0 every 2 clocks for 20 clocks, then hold 0 -> o_mode
//    stays 0, o_mode_change never asserts.
//  3 Five clean presses (each held 10, released 10 clocks) -> o_mode sequence
//    1,2,3,4,0; sw2/sw1 00,01,10,11,00; o_enable 1,1,1,1,0.
//  4 S_MODE3, i_auto_en=1, no press -> after 20 clocks o_mode=1 (wrap to S_MODE0, not OFF).
//    In S_OFF with auto_en=1 for 100 clocks -> no change.
//  5 Align press to dwell-expiry cycle in S_MODE1 -> single step to S_MODE2.
//    Next auto advance occurs 20 clocks later.
//  6 Assert i_reset for 1 clock mid-debounce and mid-dwell -> outputs at reset values next edge.
//    Held button produces a press D+3 clocks after reset release.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// Front-panel LED rate controller: debounces one push-button and steps through
// OFF/100Hz/50Hz/10Hz/1Hz, with an optional dwell-timed auto-cycle of the rates.
module led_mode_sequencer #(
  parameter int unsigned c_DEBOUNCE_CNT = 250,
  parameter int unsigned c_DWELL_CNT    = 125000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_button,
  input  logic       i_auto_en,
  output logic       o_enable,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic [2:0] o_mode,
  output logic       o_mode_change
);

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StMode0 = 3'd1,
    StMode1 = 3'd2,
    StMode2 = 3'd3,
    StMode3 = 3'd4
  } state_e;

  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic        deb_prev_q;
  logic [31:0] deb_cnt_q, deb_cnt_d;
  logic [31:0] dwell_cnt_q, dwell_cnt_d;
  state_e      state_q, state_d;
  logic        mode_change_q;
  logic        press;
  logic        dwell_expire;

  // Two-flop synchronizer for the asynchronous button; only sync_q[1] is used.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_button};
    end
  end

  // Debounce: accept the synchronized level only after it has differed for the full count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (deb_cnt_q == c_DEBOUNCE_CNT - 1) begin
        deb_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 32'd1;
      end
    end
  end

  // Debounced level, its one-cycle delayed copy (edge detect) and the debounce counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Only the debounced rising edge is a press; release is ignored.
  assign press        = deb_q & ~deb_prev_q;
  assign dwell_expire = i_auto_en && (state_q != StOff) && (dwell_cnt_q == c_DWELL_CNT - 1);

  // Next state: a press wins over a simultaneous dwell expiry; auto-advance skips OFF.
  always_comb begin
    state_d = state_q;
    if (press) begin
      case (state_q)
        StOff:   state_d = StMode0;
        StMode0: state_d = StMode1;
        StMode1: state_d = StMode2;
        StMode2: state_d = StMode3;
        default: state_d = StOff;
      endcase
    end else if (dwell_expire) begin
      case (state_q)
        StMode0: state_d = StMode1;
        StMode1: state_d = StMode2;
        StMode2: state_d = StMode3;
        StMode3: state_d = StMode0;
        default: state_d = state_q;
      endcase
    end
  end

  // Dwell counter restarts on any state change and idles at zero when not auto-cycling.
  always_comb begin
    dwell_cnt_d = '0;
    if (state_d == state_q && i_auto_en && state_q != StOff) begin
      dwell_cnt_d = dwell_cnt_q + 32'd1;
    end
  end

  // State register, dwell counter and the registered state-change pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= StOff;
      dwell_cnt_q   <= '0;
      mode_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_cnt_q   <= dwell_cnt_d;
      mode_change_q <= (state_d != state_q);
    end
  end

  // Selector controls decoded straight from the state register.
  always_comb begin
    o_enable   = 1'b0;
    o_switch_2 = 1'b0;
    o_switch_1 = 1'b0;
    unique case (state_q)
      StMode0: o_enable = 1'b1;
      StMode1: begin
        o_enable   = 1'b1;
        o_switch_1 = 1'b1;
      end
      StMode2: begin
        o_enable   = 1'b1;
        o_switch_2 = 1'b1;
      end
      StMode3: begin
        o_enable   = 1'b1;
        o_switch_2 = 1'b1;
        o_switch_1 = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mode        = state_q;
  assign o_mode_change = mode_change_q;

endmodule
